// File: rtl/sw_frame_decoder_if.sv
// Bundle of the FIFO pop, register-file req/ack and response valid/ready
// channels seen by sw_frame_decoder.
interface sw_frame_decoder_if #(
    parameter int W_WIDTH     = 8,
    parameter int FRAME_WIDTH = 32
);
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic [FRAME_WIDTH-1:0] frame_in;

    logic                   reg_req;
    logic                   reg_wr;
    logic [4:0]             reg_addr;
    logic [W_WIDTH-1:0]     reg_wdata;
    logic                   reg_ack;
    logic [W_WIDTH-1:0]     reg_rdata;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [7:0]             rsp_op_id;
    logic [W_WIDTH-1:0]     rsp_data;
    logic                   rsp_wr;
    logic                   rsp_err;

    modport master (
        input  fifo_empty,
        output fifo_rd_en,
        input  frame_in,
        output reg_req,
        output reg_wr,
        output reg_addr,
        output reg_wdata,
        input  reg_ack,
        input  reg_rdata,
        output rsp_valid,
        input  rsp_ready,
        output rsp_op_id,
        output rsp_data,
        output rsp_wr,
        output rsp_err
    );

    modport slave (
        output fifo_empty,
        input  fifo_rd_en,
        output frame_in,
        input  reg_req,
        input  reg_wr,
        input  reg_addr,
        input  reg_wdata,
        output reg_ack,
        output reg_rdata,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_op_id,
        input  rsp_data,
        input  rsp_wr,
        input  rsp_err
    );
endinterface

// File: rtl/sw_frame_decoder.sv
// Pops one request frame, runs one register access, returns a tagged response.
// Define SW_DEC_WR_RSP_EN to also answer successful writes.
module sw_frame_decoder #(
    parameter int W_WIDTH     = 8,
    parameter int FRAME_WIDTH = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    sw_frame_decoder_if.master bus,
    output logic               busy
);

    localparam int CW     = $clog2(ACK_TIMEOUT + 1);
    localparam int RSV_LO = 22;

`ifdef SW_DEC_WR_RSP_EN
    localparam bit WR_RSP = 1'b1;
`else
    localparam bit WR_RSP = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        LOAD = 3'd2,
        REQ  = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t state, state_d;

    logic [CW-1:0]      cnt, cnt_d;
    logic [7:0]         op_q, op_d;
    logic               fifo_rd_en_q, fifo_rd_en_d;
    logic               reg_req_q, reg_req_d;
    logic               reg_wr_q, reg_wr_d;
    logic [4:0]         reg_addr_q, reg_addr_d;
    logic [W_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_op_id_q, rsp_op_id_d;
    logic [W_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_wr_q, rsp_wr_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;

    logic rsv_bad;
    logic timeout;

    assign rsv_bad = |bus.frame_in[FRAME_WIDTH-1:RSV_LO];
    // The ack is checked before this, so a same-cycle ack still wins.
    assign timeout = (cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= '0;
            fifo_rd_en_q <= 1'b0;
            reg_req_q    <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_op_id_q  <= '0;
            rsp_data_q   <= '0;
            rsp_wr_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            op_q         <= op_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            reg_req_q    <= reg_req_d;
            reg_wr_q     <= reg_wr_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_op_id_q  <= rsp_op_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (!bus.fifo_empty) state_d = POP;
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                state_d = rsv_bad ? RSP : REQ;
            end
            REQ: begin
                if (bus.reg_ack) begin
                    state_d = (reg_wr_q && !WR_RSP) ? IDLE : RSP;
                end else if (timeout) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered: their next values follow the next state.
    always_comb begin
        op_d         = op_q;
        reg_wr_d     = reg_wr_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        rsp_op_id_d  = rsp_op_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_wr_d     = rsp_wr_q;
        rsp_err_d    = rsp_err_q;
        fifo_rd_en_d = (state_d == POP);
        reg_req_d    = (state_d == REQ);
        rsp_valid_d  = (state_d == RSP);
        busy_d       = (state_d != IDLE);
        cnt_d        = (state == REQ) ? cnt + CW'(1) : '0;

        unique case (state)
            LOAD: begin
                op_d        = bus.frame_in[7:0];
                reg_wr_d    = bus.frame_in[16];
                reg_addr_d  = bus.frame_in[21:17];
                reg_wdata_d = bus.frame_in[8 +: W_WIDTH];
                if (rsv_bad) begin
                    rsp_op_id_d = bus.frame_in[7:0];
                    rsp_wr_d    = bus.frame_in[16];
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end
            end
            REQ: begin
                if (state_d == RSP) begin
                    rsp_op_id_d = op_q;
                    rsp_wr_d    = reg_wr_q;
                    if (bus.reg_ack) begin
                        rsp_err_d  = 1'b0;
                        rsp_data_d = reg_wr_q ? '0 : bus.reg_rdata;
                    end else begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.fifo_rd_en = fifo_rd_en_q;
    assign bus.reg_req    = reg_req_q;
    assign bus.reg_wr     = reg_wr_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_wdata  = reg_wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_op_id  = rsp_op_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_wr     = rsp_wr_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_sw_frame_decoder.sv
// Directed bench for sw_frame_decoder: write, read, backpressure,
// reserved bits, ack timeout and its boundary, and reset mid-request.
module tb_sw_frame_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    sw_frame_decoder_if #(.W_WIDTH(8), .FRAME_WIDTH(32)) bus ();

    sw_frame_decoder #(
        .W_WIDTH(8),
        .FRAME_WIDTH(32),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic bad;

        rst_n          = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.frame_in   = '0;
        bus.reg_ack    = 1'b0;
        bus.reg_rdata  = '0;
        bus.rsp_ready  = 1'b0;
        tick();
        tick();
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("rst_req", 32'(bus.reg_req), 0);
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(bus.reg_addr), 0);
        chk("rst_op", 32'(bus.rsp_op_id), 0);
        rst_n = 1'b1;
        tick();

        // write 0x0007_5A3C, ack in first REQ cycle
        bus.frame_in   = 32'h0007_5A3C;
        bus.fifo_empty = 1'b0;
        tick();
        chk("wr_rd_en", 32'(bus.fifo_rd_en), 1);
        chk("wr_busy", 32'(busy), 1);
        bus.fifo_empty = 1'b1;
        tick();
        chk("wr_rd_en_once", 32'(bus.fifo_rd_en), 0);
        tick();
        chk("wr_req", 32'(bus.reg_req), 1);
        chk("wr_addr", 32'(bus.reg_addr), 32'h03);
        chk("wr_wr", 32'(bus.reg_wr), 1);
        chk("wr_wdata", 32'(bus.reg_wdata), 32'h5A);
        bus.reg_ack = 1'b1;
        tick();
        bus.reg_ack = 1'b0;
        chk("wr_req_drop", 32'(bus.reg_req), 0);
`ifdef SW_DEC_WR_RSP_EN
        chk("wr_valid", 32'(bus.rsp_valid), 1);
        chk("wr_op", 32'(bus.rsp_op_id), 32'h3C);
        chk("wr_data", 32'(bus.rsp_data), 0);
        chk("wr_rsp_wr", 32'(bus.rsp_wr), 1);
        chk("wr_err", 32'(bus.rsp_err), 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("wr_valid_drop", 32'(bus.rsp_valid), 0);
        chk("wr_idle", 32'(busy), 0);
`else
        chk("wr_idle", 32'(busy), 0);
        bad = bus.rsp_valid;
        for (int i = 0; i < 4; i++) begin
            tick();
            bad = bad | bus.rsp_valid;
        end
        chk("wr_no_rsp", 32'(bad), 0);
`endif

        // read 0x003E_0081, ack two cycles after req, then backpressure
        bus.frame_in   = 32'h003E_0081;
        bus.fifo_empty = 1'b0;
        tick();
        bus.fifo_empty = 1'b1;
        tick();
        tick();
        chk("rd_req", 32'(bus.reg_req), 1);
        chk("rd_addr", 32'(bus.reg_addr), 32'h1F);
        chk("rd_wr", 32'(bus.reg_wr), 0);
        tick();
        chk("rd_req_wait", 32'(bus.reg_req), 1);
        tick();
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 8'hC7;
        tick();
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = 8'h00;
        chk("rd_req_drop", 32'(bus.reg_req), 0);
        chk("rd_valid", 32'(bus.rsp_valid), 1);
        chk("rd_op", 32'(bus.rsp_op_id), 32'h81);
        chk("rd_data", 32'(bus.rsp_data), 32'hC7);
        chk("rd_err", 32'(bus.rsp_err), 0);
        chk("rd_rsp_wr", 32'(bus.rsp_wr), 0);
        bus.fifo_empty = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_op_id !== 8'h81 ||
                bus.rsp_data !== 8'hC7 || bus.rsp_err !== 1'b0 ||
                bus.fifo_rd_en !== 1'b0) bad = 1'b1;
        end
        chk("bp_stable", 32'(bad), 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_valid_drop", 32'(bus.rsp_valid), 0);
        chk("bp_no_pop_yet", 32'(bus.fifo_rd_en), 0);
        bus.frame_in = 32'h8000_0012;
        tick();
        chk("bp_pop", 32'(bus.fifo_rd_en), 1);

        // reserved bits set: error response, no register access
        bus.fifo_empty = 1'b1;
        tick();
        tick();
        chk("rsv_no_req", 32'(bus.reg_req), 0);
        chk("rsv_valid", 32'(bus.rsp_valid), 1);
        chk("rsv_op", 32'(bus.rsp_op_id), 32'h12);
        chk("rsv_err", 32'(bus.rsp_err), 1);
        chk("rsv_data", 32'(bus.rsp_data), 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // timeout: no ack for a read
        bus.frame_in   = 32'h0000_0055;
        bus.fifo_empty = 1'b0;
        tick();
        bus.fifo_empty = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.reg_req === 1'b1) n++;
            if (bus.rsp_valid === 1'b1) break;
        end
        chk("to_req_cycles", 32'(n), 15);
        chk("to_valid", 32'(bus.rsp_valid), 1);
        chk("to_req_drop", 32'(bus.reg_req), 0);
        chk("to_err", 32'(bus.rsp_err), 1);
        chk("to_data", 32'(bus.rsp_data), 0);
        chk("to_op", 32'(bus.rsp_op_id), 32'h55);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // ack in the 15th REQ cycle wins; ready high before valid
        bus.frame_in   = 32'h0002_0099;
        bus.fifo_empty = 1'b0;
        tick();
        bus.fifo_empty = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("edge_req", 32'(bus.reg_req), 1);
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 8'h3B;
        bus.rsp_ready = 1'b1;
        tick();
        bus.reg_ack = 1'b0;
        chk("edge_valid", 32'(bus.rsp_valid), 1);
        chk("edge_err", 32'(bus.rsp_err), 0);
        chk("edge_data", 32'(bus.rsp_data), 32'h3B);
        chk("edge_op", 32'(bus.rsp_op_id), 32'h99);
        tick();
        bus.rsp_ready = 1'b0;
        chk("early_ready_done", 32'(bus.rsp_valid), 0);
        chk("early_ready_idle", 32'(busy), 0);

        // reset while in REQ
        bus.frame_in   = 32'h0007_5A3C;
        bus.fifo_empty = 1'b0;
        tick();
        bus.fifo_empty = 1'b1;
        tick();
        tick();
        chk("mid_req", 32'(bus.reg_req), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_req", 32'(bus.reg_req), 0);
        chk("mid_rst_addr", 32'(bus.reg_addr), 0);
        chk("mid_rst_wdata", 32'(bus.reg_wdata), 0);
        chk("mid_rst_wr", 32'(bus.reg_wr), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        bus.reg_ack = 1'b1;
        tick();
        bus.reg_ack = 1'b0;
        chk("mid_lost_valid", 32'(bus.rsp_valid), 0);
        chk("mid_lost_busy", 32'(busy), 0);
        bus.frame_in   = 32'h003E_0081;
        bus.fifo_empty = 1'b0;
        tick();
        chk("post_rd_en", 32'(bus.fifo_rd_en), 1);
        bus.fifo_empty = 1'b1;
        tick();
        tick();
        chk("post_req", 32'(bus.reg_req), 1);
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 8'h5E;
        tick();
        bus.reg_ack = 1'b0;
        chk("post_valid", 32'(bus.rsp_valid), 1);
        chk("post_data", 32'(bus.rsp_data), 32'h5E);
        chk("post_op", 32'(bus.rsp_op_id), 32'h81);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("post_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
